// File: rtl/psum_deskew_collector.sv
// Deskews the staggered row partial sums of a systolic array column into whole vectors and buffers them in a small FIFO.
// Optional macro PSUM_RELU_EN clamps negative lanes to zero as they enter the FIFO.
module psum_deskew_collector #(
  parameter int N_ROWS         = 8,
  parameter int PARTIAL_SUM_BW = 19,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               in_valid,
  input  logic [N_ROWS*PARTIAL_SUM_BW-1:0]   psum_in,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [N_ROWS*PARTIAL_SUM_BW-1:0]   out_data,
  output logic [$clog2(FIFO_DEPTH):0]        level,
  output logic                               overflow
);

  localparam int W  = PARTIAL_SUM_BW;
  localparam int VW = N_ROWS * PARTIAL_SUM_BW;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(FIFO_DEPTH);

  logic [VW-1:0] aligned_data;
  logic [VW-1:0] wr_data;
  logic          aligned_valid;

  // Row r arrives r cycles late, so it gets N_ROWS-1-r stages to catch up with the last row.
  for (genvar gi = 0; gi < N_ROWS; gi++) begin : g_lane
    localparam int D = N_ROWS - 1 - gi;
    logic [W-1:0] lane_in;
    logic [W-1:0] lane_aligned;

    assign lane_in = psum_in[gi*W +: W];

    if (D == 0) begin : g_direct
      assign lane_aligned = lane_in;
    end else begin : g_delay
      logic [W-1:0] stage_q [D];
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < D; i++) stage_q[i] <= '0;
        end else begin
          stage_q[0] <= lane_in;
          for (int i = 1; i < D; i++) stage_q[i] <= stage_q[i-1];
        end
      end
      assign lane_aligned = stage_q[D-1];
    end

    assign aligned_data[gi*W +: W] = lane_aligned;

`ifdef PSUM_RELU_EN
    assign wr_data[gi*W +: W] = lane_aligned[W-1] ? '0 : lane_aligned;
`else
    assign wr_data[gi*W +: W] = lane_aligned;
`endif
  end

  if (N_ROWS > 1) begin : g_vld
    logic [N_ROWS-2:0] vld_q;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        vld_q <= '0;
      end else begin
        vld_q[0] <= in_valid;
        for (int i = 1; i < N_ROWS - 1; i++) vld_q[i] <= vld_q[i-1];
      end
    end
    assign aligned_valid = vld_q[N_ROWS-2];
  end else begin : g_vld_direct
    assign aligned_valid = in_valid;
  end

  logic [VW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr_q, wr_ptr_q;
  logic [LW-1:0] level_q, level_d;
  logic          overflow_q, overflow_d;
  logic          pop, full, wr_en;

  // A full FIFO still takes the incoming vector when the head leaves in the same cycle.
  always_comb begin
    pop        = (level_q != '0) && out_ready;
    full       = (level_q == DEPTH_L);
    wr_en      = aligned_valid && (!full || pop);
    overflow_d = overflow_q || (aligned_valid && full && !pop);
    level_d    = level_q;
    if (wr_en && !pop)      level_d = level_q + LW'(1);
    else if (!wr_en && pop) level_d = level_q - LW'(1);
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)   rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q    <= level_d;
      overflow_q <= overflow_d;
    end
  end

  // Gating on occupancy keeps out_data at zero whenever the FIFO is empty, including during reset.
  assign out_valid = (level_q != '0);
  assign out_data  = out_valid ? mem[rd_ptr_q] : '0;
  assign level     = level_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_psum_deskew_collector.sv
// Scoreboard bench for psum_deskew_collector: drives skewed rows, queues expected aligned vectors, checks on handshake.
module tb_psum_deskew_collector;

  localparam int N  = 8;
  localparam int W  = 19;
  localparam int VW = N * W;
  typedef logic [VW-1:0] vec_t;

  logic       clk;
  logic       rst;
  logic       in_valid;
  vec_t       psum_in;
  logic       out_valid;
  logic       out_ready;
  vec_t       out_data;
  logic [2:0] level;
  logic       overflow;

  psum_deskew_collector #(.N_ROWS(N), .PARTIAL_SUM_BW(W), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .psum_in(psum_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .level(level), .overflow(overflow)
  );

  int   n_tests = 0;
  int   n_fail  = 0;
  vec_t sb[$];
  vec_t hist[N];
  bit   hval[N];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input vec_t got, input vec_t exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic vec_t set_lane(input vec_t v, input int r, input int val);
    vec_t t = v;
    t[r*W +: W] = W'(val);
    return t;
  endfunction

  function automatic vec_t model(input vec_t v);
    vec_t t = v;
`ifdef PSUM_RELU_EN
    for (int r = 0; r < N; r++) if (t[r*W + W - 1]) t[r*W +: W] = '0;
`endif
    return t;
  endfunction

  // Row r of the bus carries the vector launched r cycles earlier; idle rows get noise.
  task automatic cyc(input bit v, input vec_t d);
    for (int i = N - 1; i > 0; i--) begin
      hist[i] = hist[i-1];
      hval[i] = hval[i-1];
    end
    hist[0] = d;
    hval[0] = v;
    for (int r = 0; r < N; r++)
      psum_in[r*W +: W] = hval[r] ? hist[r][r*W +: W] : W'($urandom);
    in_valid = v;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    for (int i = 0; i < N; i++) hval[i] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic drain(input string tag);
    out_ready = 1'b1;
    for (int i = 0; i < 30 && (sb.size() != 0 || level != 0); i++) cyc(1'b0, '0);
    chk({tag, "_sb_empty"}, vec_t'(sb.size()), '0);
    chk({tag, "_level0"}, vec_t'(level), '0);
  endtask

  // Handshake monitor: inputs are stable here, so valid&ready means a pop at the next edge.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) chk("spurious_out", vec_t'(out_valid), '0);
      else                chk("out_data", out_data, sb.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t d, first;
    rst = 1'b1; in_valid = 1'b0; psum_in = '0; out_ready = 1'b0;
    for (int i = 0; i < N; i++) begin hist[i] = '0; hval[i] = 1'b0; end
    #1;
    chk("rst_valid", vec_t'(out_valid), '0);
    chk("rst_level", vec_t'(level), '0);
    chk("rst_ovf", vec_t'(overflow), '0);
    chk("rst_data", out_data, '0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Single vector: out_valid exactly N cycles after in_valid
    out_ready = 1'b1;
    d = '0;
    for (int r = 0; r < N; r++) d = set_lane(d, r, r * 1000);
    sb.push_back(model(d));
    cyc(1'b1, d);
    for (int k = 1; k <= 10; k++) begin
      chk($sformatf("t1_valid_c%0d", k), vec_t'(out_valid), vec_t'(k == 8));
      cyc(1'b0, '0);
    end
    $display("[TB] single vector latency check done");

    // Five back-to-back vectors into a stalled 4-deep FIFO
    do_reset();
    out_ready = 1'b0;
    for (int v = 1; v <= 5; v++) begin
      d = '0;
      for (int r = 0; r < N; r++) d = set_lane(d, r, v * 100 + r);
      if (v == 1) first = d;
      if (v <= 4) sb.push_back(model(d));
      cyc(1'b1, d);
    end
    repeat (10) cyc(1'b0, '0);
    chk("t2_level_full", vec_t'(level), vec_t'(4));
    chk("t2_overflow", vec_t'(overflow), vec_t'(1));
    chk("t2_valid", vec_t'(out_valid), vec_t'(1));
    chk("t2_head_hold", out_data, model(first));
    drain("t2");
    chk("t2_overflow_sticky", vec_t'(overflow), vec_t'(1));
    $display("[TB] overflow drop check done");

    // Full FIFO with a pop in the same cycle the fifth vector aligns
    do_reset();
    chk("t3_ovf_cleared", vec_t'(overflow), '0);
    out_ready = 1'b0;
    for (int v = 1; v <= 4; v++) begin
      d = '0;
      for (int r = 0; r < N; r++) d = set_lane(d, r, -(v * 37 + r));
      sb.push_back(model(d));
      cyc(1'b1, d);
    end
    repeat (2) cyc(1'b0, '0);
    d = '0;
    for (int r = 0; r < N; r++) d = set_lane(d, r, 55555 + r);
    sb.push_back(model(d));
    cyc(1'b1, d);
    repeat (6) cyc(1'b0, '0);
    chk("t3_level_before", vec_t'(level), vec_t'(4));
    out_ready = 1'b1;
    cyc(1'b0, '0);
    out_ready = 1'b0;
    chk("t3_level_after", vec_t'(level), vec_t'(4));
    chk("t3_no_overflow", vec_t'(overflow), '0);
    drain("t3");
    $display("[TB] simultaneous pop/write at full check done");

    // Lane 3 negative, others positive
    d = '0;
    for (int r = 0; r < N; r++) d = set_lane(d, r, (r == 3) ? -5 : 7);
    first = '0;
    for (int r = 0; r < N; r++) first = set_lane(first, r, 7);
`ifdef PSUM_RELU_EN
    first = set_lane(first, 3, 0);
`else
    first = set_lane(first, 3, 'h7FFFB);
`endif
    sb.push_back(first);
    out_ready = 1'b1;
    cyc(1'b1, d);
    drain("t4");
    $display("[TB] negative lane check done");

    // Extreme values, then a back-to-back random burst
    d = '0;
    for (int r = 0; r < N; r++) d = set_lane(d, r, (r % 2 == 0) ? -262144 : 262143);
    sb.push_back(model(d));
    cyc(1'b1, d);
    for (int v = 0; v < 6; v++) begin
      d = '0;
      for (int r = 0; r < N; r++) d = set_lane(d, r, int'($urandom));
      sb.push_back(model(d));
      cyc(1'b1, d);
    end
    drain("t5");
    $display("[TB] extreme value and burst check done");

    // Reset pulse while a vector is still in the deskew pipeline
    out_ready = 1'b1;
    d = '0;
    for (int r = 0; r < N; r++) d = set_lane(d, r, 4242 + r);
    cyc(1'b1, d);
    cyc(1'b0, '0);
    cyc(1'b0, '0);
    rst = 1'b1;
    #1;
    chk("t6_rst_valid", vec_t'(out_valid), '0);
    chk("t6_rst_level", vec_t'(level), '0);
    chk("t6_rst_data", out_data, '0);
    in_valid = 1'b0;
    for (int i = 0; i < N; i++) hval[i] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 12; k++) begin
      chk($sformatf("t6_valid_c%0d", k), vec_t'(out_valid), '0);
      chk($sformatf("t6_level_c%0d", k), vec_t'(level), '0);
      cyc(1'b0, '0);
    end
    $display("[TB] mid-flight reset check done");

    chk("final_sb_empty", vec_t'(sb.size()), '0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/psum_deskew_collector.md
PSUM_DESKEW_COLLECTOR -- requirements
Module: psum_deskew_collector

Interface
REQ-001 SHALL have parameter N_ROWS, default 8, number of array rows (lanes) collected.
REQ-002 SHALL have parameter PARTIAL_SUM_BW, default 19, width of each row partial sum.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, number of aligned vectors buffered (power of two, >=2).
REQ-004 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port in_valid, input, 1, asserted in the cycle row 0's partial sum of a new output vector is present.
REQ-007 SHALL have port psum_in, input, N_ROWS*PARTIAL_SUM_BW, signed row sums from the rightmost array column; row r on bits [r*PARTIAL_SUM_BW +: PARTIAL_SUM_BW].
REQ-008 SHALL have port out_valid, output, 1, FIFO head holds an aligned vector.
REQ-009 SHALL have port out_ready, input, 1, downstream accepts the head vector.
REQ-010 SHALL have port out_data, output, N_ROWS*PARTIAL_SUM_BW, aligned vector, same lane packing as psum_in.
REQ-011 SHALL have port level, output, clog2(FIFO_DEPTH)+1, current FIFO occupancy.
REQ-012 SHALL have port overflow, output, 1, sticky flag: an aligned vector was dropped.

Function
REQ-013 SHALL treat row r of vector k as valid exactly r cycles after the in_valid cycle of vector k; in_valid may be asserted every cycle.
REQ-014 SHALL delay row r by N_ROWS-1-r register stages and in_valid by N_ROWS-1 stages, so all lanes of vector k align in cycle t+N_ROWS-1, where t is the in_valid cycle.
REQ-015 SHALL write the aligned vector into the FIFO at the end of cycle t+N_ROWS-1; when the FIFO is empty, out_valid SHALL first assert in cycle t+N_ROWS with that vector on out_data.
REQ-016 SHALL assert out_valid iff level != 0; out_data SHALL show the oldest stored vector and stay stable while out_valid=1 and out_ready=0.
REQ-017 SHALL pop the head on a cycle with out_valid=1 and out_ready=1; out_ready while empty SHALL have no effect.
REQ-018 SHALL, when an aligned write meets a full FIFO with no pop that cycle, drop the vector, leave FIFO contents and level unchanged, and set overflow=1.
REQ-019 SHALL accept the write on a simultaneous pop and aligned write when full; level stays FIFO_DEPTH; overflow is not set.
REQ-020 SHALL, on a simultaneous pop and write at other levels, leave level unchanged and keep FIFO order.
REQ-021 SHALL wrap read/write pointers modulo FIFO_DEPTH.
REQ-022 SHALL pass lane values unchanged (no arithmetic, no width change) except as given in REQ-026.
REQ-023 SHALL hold overflow at 1 until rst.

Reset
REQ-024 SHALL, while rst=1, force all delay stages, FIFO pointers and level to 0, and force out_valid=0, out_data=0 and overflow=0, independent of clk.
REQ-025 SHALL discard all in-flight and buffered vectors when rst asserts mid-operation; no pre-reset vector SHALL appear after rst deasserts.

Configuration
REQ-026 SHALL, with macro PSUM_RELU_EN defined, replace each negative lane with 0 at FIFO write (ReLU); without it, lanes SHALL be stored as signed two's complement, unchanged.

Verification
REQ-027 SHALL test: one vector, row r = r*1000, in_valid at cycle 10, out_ready=1 -> out_valid only in cycle 18, out_data lanes 0,1000,...,7000.
REQ-028 SHALL test: 5 back-to-back vectors, out_ready=0 -> level=4, overflow=1, then draining yields vectors 1-4 in order, 5th absent.
REQ-029 SHALL test: FIFO full, out_ready=1 in the cycle a 5th aligned vector arrives -> level stays 4, overflow=0, 5th vector emerges last.
REQ-030 SHALL test: lane 3 = -5, other lanes = 7 -> lane 3 output 0 with PSUM_RELU_EN, 0x7FFFB without; other lanes 7.
REQ-031 SHALL test: lanes alternately -262144 and 262143 (no macro) -> output bit-identical to input.
REQ-032 SHALL test: rst pulsed 3 cycles after in_valid of a vector -> out_valid=0, level=0 during and after reset; no output for that vector.
